// File: rtl/gate_lane_scheduler_pkg.sv
// Shared types and default constants for the single-lane barrier scheduler.
package gate_lane_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_CLOSE = 2'd2
    } state_t;

    typedef enum logic {
        DIR_ENT = 1'b0,
        DIR_EXT = 1'b1
    } dir_t;

    localparam int DEF_CAPACITY     = 10;
    localparam int DEF_CNT_W        = 4;
    localparam int DEF_OPEN_MAX     = 16;
    localparam int DEF_CLOSE_CYCLES = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gate_lane_scheduler_lane_timer.sv
// Loadable down-counter shared by the open-phase timeout and the close-phase duration.
module lane_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/gate_lane_scheduler.sv
// Shared entry/exit barrier sequencer: round-robin arbitration, open/close phasing
// and the lot occupancy counter with full/empty guarding.
module gate_lane_scheduler
    import gate_lane_scheduler_pkg::*;
#(
    parameter int CAPACITY     = DEF_CAPACITY,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int OPEN_MAX     = DEF_OPEN_MAX,
    parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             ent,
    input  logic             ext,
    input  logic             pass,
    output logic             ent_gnt,
    output logic             ext_gnt,
    output logic             open,
    output logic             close,
    output logic             timeout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output state_t           dbg_state
);

    localparam int TMR_W = $clog2(max_int(OPEN_MAX, CLOSE_CYCLES) + 1);

    // The timer holds the number of cycles left after the current one,
    // so a phase of N cycles loads N-1 and ends on the cycle it reads zero.
    localparam logic [TMR_W-1:0] OPEN_LOAD  = TMR_W'(OPEN_MAX - 1);
    localparam logic [TMR_W-1:0] CLOSE_LOAD = TMR_W'(CLOSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAP_VAL    = CNT_W'(CAPACITY);

    state_t           state_q,   state_d;
    dir_t             dir_q,     dir_d;
    dir_t             last_q,    last_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic             ent_gnt_q, ent_gnt_d;
    logic             ext_gnt_q, ext_gnt_d;
    logic             open_q,    open_d;
    logic             close_q,   close_d;
    logic             timeout_q, timeout_d;

    logic             full_w;
    logic             empty_w;
    logic             ent_ok;
    logic             ext_ok;
    dir_t             grant_dir;

    logic             tmr_load;
    logic             tmr_en;
    logic [TMR_W-1:0] tmr_load_val;
    logic             tmr_zero;

    lane_timer #(
        .W (TMR_W)
    ) u_lane_timer (
        .clk      (clk),
        .clr_n    (clr_n),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_load_val),
        .zero     (tmr_zero)
    );

    assign full_w  = (count_q == CAP_VAL);
    assign empty_w = (count_q == '0);
    assign ent_ok  = ent && !full_w;
    assign ext_ok  = ext && !empty_w;

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        last_d       = last_q;
        count_d      = count_q;
        ent_gnt_d    = 1'b0;
        ext_gnt_d    = 1'b0;
        timeout_d    = 1'b0;
        tmr_load     = 1'b0;
        tmr_en       = 1'b0;
        tmr_load_val = OPEN_LOAD;
        grant_dir    = DIR_ENT;

        case (state_q)
            ST_IDLE: begin
                if (ent_ok || ext_ok) begin
                    // On a tie the direction not served last wins.
                    if (ent_ok && ext_ok) begin
                        grant_dir = (last_q == DIR_EXT) ? DIR_ENT : DIR_EXT;
                    end else begin
                        grant_dir = ent_ok ? DIR_ENT : DIR_EXT;
                    end
                    state_d      = ST_OPEN;
                    dir_d        = grant_dir;
                    last_d       = grant_dir;
                    ent_gnt_d    = (grant_dir == DIR_ENT);
                    ext_gnt_d    = (grant_dir == DIR_EXT);
                    tmr_load     = 1'b1;
                    tmr_load_val = OPEN_LOAD;
                end
            end
            ST_OPEN: begin
                if (pass) begin
                    state_d      = ST_CLOSE;
                    count_d      = (dir_q == DIR_ENT) ? count_q + CNT_W'(1)
                                                      : count_q - CNT_W'(1);
                    tmr_load     = 1'b1;
                    tmr_load_val = CLOSE_LOAD;
                end else if (tmr_zero) begin
                    state_d      = ST_CLOSE;
                    timeout_d    = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = CLOSE_LOAD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_CLOSE: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        open_d  = (state_d == ST_OPEN);
        close_d = (state_d == ST_CLOSE);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_ENT;
            last_q    <= DIR_EXT;
            count_q   <= '0;
            ent_gnt_q <= 1'b0;
            ext_gnt_q <= 1'b0;
            open_q    <= 1'b0;
            close_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            last_q    <= last_d;
            count_q   <= count_d;
            ent_gnt_q <= ent_gnt_d;
            ext_gnt_q <= ext_gnt_d;
            open_q    <= open_d;
            close_q   <= close_d;
            timeout_q <= timeout_d;
        end
    end

    assign ent_gnt   = ent_gnt_q;
    assign ext_gnt   = ext_gnt_q;
    assign open      = open_q;
    assign close     = close_q;
    assign timeout   = timeout_q;
    assign count     = count_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_gate_lane_scheduler.sv
// Bench for gate_lane_scheduler: transaction-level lane model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_gate_lane_scheduler;
    import gate_lane_scheduler_pkg::*;

    localparam int CAP       = 10;
    localparam int CNT_W     = 4;
    localparam int OPEN_MAX  = 16;
    localparam int CLOSE_CYC = 4;

    // clock / reset
    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    logic ent   = 1'b0;
    logic ext   = 1'b0;
    logic pass  = 1'b0;

    logic             ent_gnt, ext_gnt, open, close, timeout, full, empty;
    logic [CNT_W-1:0] count;
    state_t           dbg_state;

    always #5 clk = ~clk;

    gate_lane_scheduler #(
        .CAPACITY     (CAP),
        .CNT_W        (CNT_W),
        .OPEN_MAX     (OPEN_MAX),
        .CLOSE_CYCLES (CLOSE_CYC)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .ent       (ent),
        .ext       (ext),
        .pass      (pass),
        .ent_gnt   (ent_gnt),
        .ext_gnt   (ext_gnt),
        .open      (open),
        .close     (close),
        .timeout   (timeout),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .dbg_state (dbg_state)
    );

    // lane model: phase 0 idle, 1 open, 2 close
    int m_phase, m_open_n, m_close_n, m_cnt;
    bit m_last_ent, m_dir_ent;
    bit e_ent_gnt, e_ext_gnt, e_timeout;

    // scoreboard: expected grant sequence, {ent_gnt, ext_gnt}
    logic [1:0] exp_q[$];

    int checks = 0;
    int errors = 0;
    int acc_open, acc_close, acc_entg, acc_extg, acc_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase    = 0;
        m_open_n   = 0;
        m_close_n  = 0;
        m_cnt      = 0;
        m_last_ent = 1'b0;
        m_dir_ent  = 1'b0;
        e_ent_gnt  = 1'b0;
        e_ext_gnt  = 1'b0;
        e_timeout  = 1'b0;
        exp_q.delete();
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_step(input bit e, input bit x, input bit p);
        bit eok, xok, pick_ent;
        e_ent_gnt = 1'b0;
        e_ext_gnt = 1'b0;
        e_timeout = 1'b0;
        case (m_phase)
            0: begin
                eok = e && (m_cnt < CAP);
                xok = x && (m_cnt > 0);
                if (eok || xok) begin
                    pick_ent   = (eok && xok) ? !m_last_ent : eok;
                    m_dir_ent  = pick_ent;
                    m_last_ent = pick_ent;
                    e_ent_gnt  = pick_ent;
                    e_ext_gnt  = !pick_ent;
                    exp_q.push_back({pick_ent, !pick_ent});
                    m_phase    = 1;
                    m_open_n   = 1;
                end
            end
            1: begin
                if (p) begin
                    m_cnt     = m_dir_ent ? m_cnt + 1 : m_cnt - 1;
                    m_phase   = 2;
                    m_close_n = 1;
                end else if (m_open_n == OPEN_MAX) begin
                    e_timeout = 1'b1;
                    m_phase   = 2;
                    m_close_n = 1;
                end else begin
                    m_open_n++;
                end
            end
            default: begin
                if (m_close_n == CLOSE_CYC) m_phase = 0;
                else m_close_n++;
            end
        endcase
    endtask

    task automatic acc_reset();
        acc_open  = 0;
        acc_close = 0;
        acc_entg  = 0;
        acc_extg  = 0;
        acc_to    = 0;
    endtask

    // One clock: compare this cycle's outputs, then drive inputs for the next edge.
    task automatic cycle(input bit e, input bit x, input bit p);
        @(negedge clk);
        check("ent_gnt", ent_gnt, e_ent_gnt);
        check("ext_gnt", ext_gnt, e_ext_gnt);
        check("timeout", timeout, e_timeout);
        check("open",    open,    m_phase == 1);
        check("close",   close,   m_phase == 2);
        check("count",   count,   m_cnt);
        check("full",    full,    m_cnt == CAP);
        check("empty",   empty,   m_cnt == 0);
        check("state",   dbg_state, m_phase);
        if (ent_gnt || ext_gnt) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL gnt_order actual=%0d expected=none at %0t", {ent_gnt, ext_gnt}, $time);
            end else begin
                check("gnt_order", {ent_gnt, ext_gnt}, exp_q.pop_front());
            end
        end
        acc_open  += int'(open);
        acc_close += int'(close);
        acc_entg  += int'(ent_gnt);
        acc_extg  += int'(ext_gnt);
        acc_to    += int'(timeout);
        ent  = e;
        ext  = x;
        pass = p;
        model_step(e, x, p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_n = 1'b0;
        ent   = 1'b0;
        ext   = 1'b0;
        pass  = 1'b0;
        model_reset();
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    // Hold the request until granted, then pulse pass on OPEN cycle pass_cyc (0 = never).
    task automatic txn(input bit e, input bit x, input int pass_cyc);
        bit got;
        int k;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(e, x, 1'b0);
            if (m_phase == 1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL txn_grant actual=0 expected=1 at %0t", $time);
            return;
        end
        k = 1;
        while (m_phase != 0 && k < 100) begin
            cycle(1'b0, 1'b0, k == pass_cyc);
            k++;
        end
        if (m_phase != 0) begin
            checks++;
            errors++;
            $display("FAIL txn_done actual=%0d expected=0 at %0t", m_phase, $time);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pe, px, pp;
        model_reset();

        // reset state
        do_reset();
        #1;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full",  full,  0);
        check("rst_open",  open,  0);
        check("rst_close", close, 0);

        // single entry, pass on 3rd OPEN cycle
        acc_reset();
        txn(1'b1, 1'b0, 3);
        check("se_entg",  acc_entg,  1);
        check("se_open",  acc_open,  3);
        check("se_close", acc_close, 4);
        check("se_count", m_cnt,     1);

        // tie arbitration from count 5 with exit served last
        do_reset();
        repeat (6) txn(1'b1, 1'b0, 2);
        txn(1'b0, 1'b1, 2);
        check("tie_pre_count", m_cnt, 5);
        acc_reset();
        txn(1'b1, 1'b1, 2);
        check("tie1_entg", acc_entg, 1);
        check("tie1_count", m_cnt, 6);
        acc_reset();
        txn(1'b1, 1'b1, 2);
        check("tie2_extg", acc_extg, 1);
        check("tie2_count", m_cnt, 5);
        acc_reset();
        txn(1'b1, 1'b1, 2);
        check("tie3_entg", acc_entg, 1);
        check("tie3_count", m_cnt, 6);

        // full guard
        do_reset();
        repeat (CAP) txn(1'b1, 1'b0, 1);
        check("full_count", m_cnt, 10);
        acc_reset();
        repeat (50) cycle(1'b1, 1'b0, 1'b0);
        check("full_no_entg", acc_entg, 0);
        txn(1'b0, 1'b1, 2);
        check("full_exit_count", m_cnt, 9);

        // empty guard
        do_reset();
        acc_reset();
        repeat (30) cycle(1'b0, 1'b1, 1'b0);
        check("empty_no_extg", acc_extg, 0);

        // timeout, then pass on the expiry cycle
        do_reset();
        acc_reset();
        txn(1'b1, 1'b0, 0);
        check("to_open", acc_open, 16);
        check("to_pulse", acc_to, 1);
        check("to_close", acc_close, 4);
        check("to_count", m_cnt, 0);
        acc_reset();
        txn(1'b1, 1'b0, 16);
        check("tp_open", acc_open, 16);
        check("tp_pulse", acc_to, 0);
        check("tp_count", m_cnt, 1);

        // asynchronous reset in the middle of OPEN
        do_reset();
        repeat (7) txn(1'b1, 1'b0, 2);
        check("ar_pre_count", m_cnt, 7);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        #3;
        clr_n = 1'b0;
        ent   = 1'b0;
        ext   = 1'b0;
        pass  = 1'b0;
        #1;
        check("ar_open",  open,  0);
        check("ar_close", close, 0);
        check("ar_count", count, 0);
        check("ar_empty", empty, 1);
        model_reset();
        @(negedge clk);
        clr_n = 1'b1;
        acc_reset();
        txn(1'b1, 1'b0, 2);
        check("ar_next_entg", acc_entg, 1);
        check("ar_next_count", m_cnt, 1);

        // randomized traffic in segments with shifting bias
        do_reset();
        for (int seg = 0; seg < 8; seg++) begin
            pe = (seg % 2 == 0) ? 80 : 25;
            px = (seg % 2 == 0) ? 25 : 80;
            pp = (seg >= 4) ? 6 : 35;
            for (int i = 0; i < 300; i++) begin
                cycle($urandom_range(0, 99) < pe,
                      $urandom_range(0, 99) < px,
                      $urandom_range(0, 99) < pp);
            end
        end
        repeat (30) cycle(1'b0, 1'b0, 1'b1);

        check("gnt_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
